cdb_arbiter: RTL and testbench

//  Parametrised common-data-bus arbiter for the out-of-order core.

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/cdb_channel_fifo.sv | 84 ++++++++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and sizing helpers for the common-data-bus arbiter.
package cdb_pkg;

   localparam int CDB_WIDTH_DEF = 31;
   localparam int CDB_ROB_DEF   = 2;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // Default-width FIFO entry; the top re-declares it at its own widths.
   typedef struct packed {
      logic [CDB_ROB_DEF:0]   rob;
      logic [CDB_WIDTH_DEF:0] value;
   } cdb_entry_t;

   // Pointer width: a single-entry FIFO still gets a 1-bit pointer.
   function automatic int ptr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Count width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/cdb_channel_fifo.sv
// Per-channel result FIFO. Depth need not be a power of two, so pointers
// wrap explicitly at DEPTH-1. Ready is derived from the registered count only.
module cdb_channel_fifo
   import cdb_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = cdb_entry_t
) (
   input  logic   clk,
   input  logic   globalReset_n,
   input  logic   flush,
   input  logic   push,
   input  logic   pop,
   input  entry_t wdata,
   output entry_t rdata,
   output logic   ready,
   output logic   not_empty
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign ready     = globalReset_n & ~flush & (count_q < CW'(DEPTH));
   assign not_empty = (count_q != '0);
   assign rdata     = mem_q[rd_ptr_q];
   assign do_push   = push & ready;
   assign do_pop    = pop & not_empty & ~flush;

   // Next-state for storage, pointers and occupancy; flush empties the FIFO.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!globalReset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is data-path only and needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: CH per-channel FIFOs, one grant per cycle onto a
// registered broadcast. Selection uses pre-edge FIFO state, so a result
// pushed at an edge is never broadcast at that same edge.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int WIDTH    = 31,
   parameter int ROB      = 2,
   parameter int CH       = 4,
   parameter int DEPTH    = 2,
   parameter int ARB_MODE = 0
) (
   input  logic                      clk,
   input  logic                      globalReset_n,
   input  logic                      flush,
   input  logic [CH-1:0]             fuValid,
   input  logic [CH-1:0][WIDTH:0]    fuResult,
   input  logic [CH-1:0][ROB:0]      fuRob,
   output logic [CH-1:0]             fuReady,
   output logic                      validBroadcast,
   output logic [WIDTH:0]            result,
   output logic [ROB:0]              robEntry,
   output logic [$clog2(CH)-1:0]     grantCh
);

   localparam int        GW   = $clog2(CH);
   localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

   typedef struct packed {
      logic [ROB:0]   rob;
      logic [WIDTH:0] value;
   } entry_t;

   entry_t          wdata [CH];
   entry_t          head  [CH];
   logic [CH-1:0]   not_empty;
   logic [CH-1:0]   pop_vec;

   logic            gnt_found;
   logic [GW-1:0]   gnt_idx;
   logic            grant;

   logic            valid_q, valid_d;
   logic [WIDTH:0]  result_q, result_d;
   logic [ROB:0]    rob_q, rob_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_q, rr_d;

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      assign wdata[gi] = {fuRob[gi], fuResult[gi]};

      cdb_channel_fifo #(
         .DEPTH   (DEPTH),
         .entry_t (entry_t)
      ) u_fifo (
         .clk           (clk),
         .globalReset_n (globalReset_n),
         .flush         (flush),
         .push          (fuValid[gi]),
         .pop           (pop_vec[gi]),
         .wdata         (wdata[gi]),
         .rdata         (head[gi]),
         .ready         (fuReady[gi]),
         .not_empty     (not_empty[gi])
      );
   end

   // Rotate-and-priority-encode: scan from the start channel, wrapping mod CH.
   always_comb begin
      int start;
      int idx;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      start     = (MODE == ARB_FIXED) ? 0 : int'(rr_q);
      idx       = 0;
      for (int k = 0; k < CH; k++) begin
         idx = start + k;
         if (idx >= CH) idx = idx - CH;
         if (!gnt_found && not_empty[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = GW'(idx);
         end
      end
   end

   // Pop the winner and compute the broadcast register and RR pointer.
   always_comb begin
      grant    = gnt_found & ~flush;
      pop_vec  = grant ? (CH'(1) << gnt_idx) : '0;
      valid_d  = grant;
      result_d = result_q;
      rob_d    = rob_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      if (grant) begin
         result_d = head[gnt_idx].value;
         rob_d    = head[gnt_idx].rob;
         grant_d  = gnt_idx;
         rr_d     = (gnt_idx == GW'(CH - 1)) ? '0 : gnt_idx + GW'(1);
      end
      if (flush) begin
         rr_d = '0;
      end
   end

   // Broadcast register and RR pointer; reset takes precedence over flush.
   always_ff @(posedge clk) begin
      if (!globalReset_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         rob_q    <= '0;
         grant_q  <= '0;
         rr_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         rob_q    <= rob_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
      end
   end

   assign validBroadcast = valid_q;
   assign result         = result_q;
   assign robEntry       = rob_q;
   assign grantCh        = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus.
module tb_cdb_arbiter;

   logic              clk = 1'b0;
   logic              globalReset_n;
   logic              flush;
   logic [3:0]        fuValid;
   logic [3:0][31:0]  fuResult;
   logic [3:0][2:0]   fuRob;

   logic [3:0]  rdy_rr, rdy_fx;
   logic        vb_rr, vb_fx;
   logic [31:0] res_rr, res_fx;
   logic [2:0]  rob_rr, rob_fx;
   logic [1:0]  gc_rr, gc_fx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.WIDTH(31), .ROB(2), .CH(4), .DEPTH(2), .ARB_MODE(0)) u_rr (
      .clk(clk), .globalReset_n(globalReset_n), .flush(flush),
      .fuValid(fuValid), .fuResult(fuResult), .fuRob(fuRob),
      .fuReady(rdy_rr), .validBroadcast(vb_rr), .result(res_rr),
      .robEntry(rob_rr), .grantCh(gc_rr)
   );

   cdb_arbiter #(.WIDTH(31), .ROB(2), .CH(4), .DEPTH(2), .ARB_MODE(1)) u_fx (
      .clk(clk), .globalReset_n(globalReset_n), .flush(flush),
      .fuValid(fuValid), .fuResult(fuResult), .fuRob(fuRob),
      .fuReady(rdy_fx), .validBroadcast(vb_fx), .result(res_fx),
      .robEntry(rob_fx), .grantCh(gc_fx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      globalReset_n = 1'b0;
      flush         = 1'b0;
      fuValid       = 4'b0000;
      tick();
      tick();
      globalReset_n = 1'b1;
   endtask

   task automatic test_reset();
      globalReset_n = 1'b0;
      flush         = 1'b0;
      fuValid       = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         fuResult[i] = 32'hDEAD_0000 + 32'(i);
         fuRob[i]    = 3'(i + 1);
      end
      tick(); tick(); tick();
      checks++; if (rdy_rr !== 4'b0000) begin errors++; $display("FAIL reset_rdy_rr got %b exp 0000", rdy_rr); end
      checks++; if (rdy_fx !== 4'b0000) begin errors++; $display("FAIL reset_rdy_fx got %b exp 0000", rdy_fx); end
      checks++; if (vb_rr !== 1'b0) begin errors++; $display("FAIL reset_vb_rr got %b exp 0", vb_rr); end
      checks++; if (vb_fx !== 1'b0) begin errors++; $display("FAIL reset_vb_fx got %b exp 0", vb_fx); end
      checks++; if (res_rr !== 32'h0 || rob_rr !== 3'd0 || gc_rr !== 2'd0) begin errors++; $display("FAIL reset_bus_rr got res=%h rob=%0d gc=%0d exp 0/0/0", res_rr, rob_rr, gc_rr); end
      checks++; if (res_fx !== 32'h0 || rob_fx !== 3'd0 || gc_fx !== 2'd0) begin errors++; $display("FAIL reset_bus_fx got res=%h rob=%0d gc=%0d exp 0/0/0", res_fx, rob_fx, gc_fx); end
      globalReset_n = 1'b1;
      fuValid       = 4'b0000;
      tick();
      checks++; if (rdy_rr !== 4'b1111) begin errors++; $display("FAIL release_rdy_rr got %b exp 1111", rdy_rr); end
      checks++; if (rdy_fx !== 4'b1111) begin errors++; $display("FAIL release_rdy_fx got %b exp 1111", rdy_fx); end
      checks++; if (vb_rr !== 1'b0) begin errors++; $display("FAIL release_vb_rr got %b exp 0", vb_rr); end
   endtask

   task automatic test_single();
      do_reset();
      fuValid     = 4'b0100;
      fuRob[2]    = 3'd3;
      fuResult[2] = 32'h0000_1234;
      tick();
      fuValid = 4'b0000;
      checks++; if (vb_rr !== 1'b0) begin errors++; $display("FAIL single_early got vb=%b exp 0", vb_rr); end
      tick();
      checks++; if (vb_rr !== 1'b1 || rob_rr !== 3'd3 || res_rr !== 32'h1234 || gc_rr !== 2'd2) begin errors++; $display("FAIL single_rr got vb=%b rob=%0d res=%h gc=%0d exp 1/3/1234/2", vb_rr, rob_rr, res_rr, gc_rr); end
      checks++; if (vb_fx !== 1'b1 || rob_fx !== 3'd3 || res_fx !== 32'h1234 || gc_fx !== 2'd2) begin errors++; $display("FAIL single_fx got vb=%b rob=%0d res=%h gc=%0d exp 1/3/1234/2", vb_fx, rob_fx, res_fx, gc_fx); end
      tick();
      checks++; if (vb_rr !== 1'b0) begin errors++; $display("FAIL single_after got vb=%b exp 0", vb_rr); end
      checks++; if (res_rr !== 32'h1234 || gc_rr !== 2'd2 || rob_rr !== 3'd3) begin errors++; $display("FAIL single_hold got res=%h gc=%0d rob=%0d exp 1234/2/3", res_rr, gc_rr, rob_rr); end
   endtask

   // All channels push every cycle; value = (channel << 8) | edge number.
   task automatic test_saturate();
      logic [1:0]  g;
      logic [31:0] exp_res;
      logic [3:0]  exp_rdy;
      do_reset();
      for (int i = 0; i < 4; i++) fuRob[i] = 3'(i);
      for (int k = 1; k <= 9; k++) begin
         for (int i = 0; i < 4; i++) fuResult[i] = 32'((i << 8) | k);
         fuValid = 4'b1111;
         tick();
         if (k == 1) begin
            checks++; if (rdy_rr !== 4'b1111 || rdy_fx !== 4'b1111) begin errors++; $display("FAIL sat_first_rdy got rr=%b fx=%b exp 1111", rdy_rr, rdy_fx); end
            checks++; if (vb_rr !== 1'b0) begin errors++; $display("FAIL sat_first_vb got %b exp 0", vb_rr); end
         end else begin
            g       = 2'((k - 2) % 4);
            exp_rdy = 4'(1 << ((k - 2) % 4));
            checks++; if (vb_rr !== 1'b1 || gc_rr !== g) begin errors++; $display("FAIL rr_grant edge %0d got vb=%b gc=%0d exp 1/%0d", k, vb_rr, gc_rr, g); end
            checks++; if (rdy_rr !== exp_rdy) begin errors++; $display("FAIL rr_ready edge %0d got %b exp %b", k, rdy_rr, exp_rdy); end
            if (k <= 5) begin
               exp_res = 32'((int'(g) << 8) | 1);
               checks++; if (res_rr !== exp_res || rob_rr !== 3'(g)) begin errors++; $display("FAIL rr_data edge %0d got res=%h rob=%0d exp %h/%0d", k, res_rr, rob_rr, exp_res, g); end
            end
            checks++; if (vb_fx !== 1'b1 || gc_fx !== 2'd0) begin errors++; $display("FAIL fx_grant edge %0d got vb=%b gc=%0d exp 1/0", k, vb_fx, gc_fx); end
            checks++; if (rdy_fx !== 4'b0001) begin errors++; $display("FAIL fx_ready edge %0d got %b exp 0001", k, rdy_fx); end
            exp_res = 32'(k - 1);
            checks++; if (res_fx !== exp_res) begin errors++; $display("FAIL fx_data edge %0d got %h exp %h", k, res_fx, exp_res); end
         end
      end
      fuValid = 4'b0000;
   endtask

   // Channel 1 fills behind busy channel 0 in fixed mode; order survives the wrap.
   task automatic test_full_wrap();
      do_reset();
      fuValid     = 4'b0011;
      fuRob[0]    = 3'd0;
      fuResult[0] = 32'hA0;
      fuRob[1]    = 3'd1;
      fuResult[1] = 32'h11;
      tick();
      fuResult[1] = 32'h12;
      tick();
      checks++; if (vb_fx !== 1'b1 || gc_fx !== 2'd0) begin errors++; $display("FAIL full_e2 got vb=%b gc=%0d exp 1/0", vb_fx, gc_fx); end
      checks++; if (rdy_fx[1] !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", rdy_fx[1]); end
      fuResult[1] = 32'h13;
      tick();
      checks++; if (gc_fx !== 2'd0 || rdy_fx[1] !== 1'b0) begin errors++; $display("FAIL full_e3 got gc=%0d rdy1=%b exp 0/0", gc_fx, rdy_fx[1]); end
      fuValid = 4'b0000;
      tick();
      checks++; if (vb_fx !== 1'b1 || gc_fx !== 2'd0 || res_fx !== 32'hA0) begin errors++; $display("FAIL full_e4 got vb=%b gc=%0d res=%h exp 1/0/a0", vb_fx, gc_fx, res_fx); end
      tick();
      checks++; if (vb_fx !== 1'b1 || gc_fx !== 2'd1 || res_fx !== 32'h11) begin errors++; $display("FAIL wrap_first got vb=%b gc=%0d res=%h exp 1/1/11", vb_fx, gc_fx, res_fx); end
      fuValid     = 4'b0010;
      fuResult[1] = 32'h14;
      tick();
      fuValid = 4'b0000;
      checks++; if (vb_fx !== 1'b1 || gc_fx !== 2'd1 || res_fx !== 32'h12) begin errors++; $display("FAIL wrap_second got vb=%b gc=%0d res=%h exp 1/1/12", vb_fx, gc_fx, res_fx); end
      tick();
      checks++; if (vb_fx !== 1'b1 || gc_fx !== 2'd1 || res_fx !== 32'h14) begin errors++; $display("FAIL wrap_third got vb=%b gc=%0d res=%h exp 1/1/14", vb_fx, gc_fx, res_fx); end
      tick();
      checks++; if (vb_fx !== 1'b0) begin errors++; $display("FAIL wrap_drain got vb=%b exp 0", vb_fx); end
   endtask

   // Five entries in flight when flush hits; nothing may emerge afterwards.
   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         fuRob[i]    = 3'(i + 4);
         fuResult[i] = 32'hF000 + 32'(i);
      end
      fuValid = 4'b1111;
      tick();
      fuValid = 4'b0011;
      tick();
      checks++; if (vb_rr !== 1'b1 || gc_rr !== 2'd0 || vb_fx !== 1'b1 || gc_fx !== 2'd0) begin errors++; $display("FAIL flush_pre got rr=%b/%0d fx=%b/%0d exp 1/0", vb_rr, gc_rr, vb_fx, gc_fx); end
      flush   = 1'b1;
      fuValid = 4'b0101;
      #1;
      checks++; if (rdy_rr !== 4'b0000 || rdy_fx !== 4'b0000) begin errors++; $display("FAIL flush_rdy got rr=%b fx=%b exp 0000", rdy_rr, rdy_fx); end
      tick();
      flush   = 1'b0;
      fuValid = 4'b0000;
      #1;
      checks++; if (vb_rr !== 1'b0 || vb_fx !== 1'b0) begin errors++; $display("FAIL flush_vb got rr=%b fx=%b exp 0", vb_rr, vb_fx); end
      checks++; if (rdy_rr !== 4'b1111 || rdy_fx !== 4'b1111) begin errors++; $display("FAIL flush_after_rdy got rr=%b fx=%b exp 1111", rdy_rr, rdy_fx); end
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++; if (vb_rr !== 1'b0 || vb_fx !== 1'b0) begin errors++; $display("FAIL flush_quiet %0d got rr=%b fx=%b exp 0", n, vb_rr, vb_fx); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      globalReset_n = 1'b0;
      flush         = 1'b0;
      fuValid       = 4'b0000;
      fuResult      = '0;
      fuRob         = '0;
      test_reset();
      test_single();
      test_saturate();
      test_full_wrap();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
